rf_wport_arb: RTL and testbench
===============================

Name: rf_wport_arb

Overview:
Arbiter and sequencer for the register file's single write port. It shares the port between the pipeline W stage, which has fixed priority, and the multi-cycle mult/div unit. The mult/div unit uses a valid/ready handshake into a small FIFO. A starvation counter bounds how long the mult/div unit can wait, and a busy mask exports pending writes to the hazard unit.

Parameters:
DEPTH, 2, FIFO entries for mult/div writes; power of 2, range 2..8.
STARVE_MAX, 4, cycles the FIFO head may wait before W is stalled; range 1..15.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous active-low reset; 0 = reset asserted.
w_we  input  1  W-stage write request.
w_a3  input  5  W-stage destination register.
w_wd  input  32  W-stage write data.
w_pc  input  32  W-stage PC, for trace.
w_stall  output  1  freeze the W stage; upstream must hold w_* stable.
md_valid  input  1  mult/div write request.
md_ready  output  1  FIFO can accept a request.
md_a3  input  5  mult/div destination register.
md_wd  input  32  mult/div write data.
md_pc  input  32  mult/div issuing PC.
rf_we  output  1  register file write enable.
rf_a3  output  5  register file write address.
rf_wd  output  32  register file write data.
rf_wpc  output  32  PC of the granted write.
busy_mask  output  32  one-hot OR of the a3 fields of all valid FIFO entries.

Behaviour:
- Reset (asynchronous, reset=0):
  - FIFO is emptied: pointers, count, starvation counter, state all cleared; state = IDLE.
  - While reset is asserted: rf_we=0, rf_a3=0, rf_wd=0, rf_wpc=0, w_stall=0, md_ready=0, busy_mask=0.
  - Reset mid-operation discards all pending entries; none is ever written afterwards.
- md_ready = !full and reset deasserted. It is computed from the current count only; there is no same-cycle pass-through when full.
- Push occurs on the rising edge when md_valid && md_ready. If md_a3==0 the request is accepted but not stored.
- Grant is combinational each cycle, in priority order:
  (1) state FORCE: grant the FIFO head, w_stall=1.
  (2) w_we && w_a3!=0: grant W.
  (3) FIFO non-empty: grant the head.
  (4) otherwise rf_we=0.
- rf_* carries the granted source's fields. The register file samples the write on the same edge.
- A W request with w_a3==0 never asserts rf_we and does not block the FIFO.
- Pop happens on the edge at which the head is granted. Latency from md accept to rf_we is at least 1 cycle.
- Simultaneous push and pop: count is unchanged. Entries drain in strict FIFO order, so the later write to the same register wins.
- States:
  - IDLE: FIFO empty. Goes to WAIT on push.
  - WAIT: FIFO non-empty. The counter increments each cycle the head is not granted and clears on every pop. When the counter reaches STARVE_MAX it goes to FORCE. It returns to IDLE when the FIFO becomes empty.
  - FORCE: lasts exactly one cycle. The head is granted and the counter cleared. Next state is WAIT if entries remain, else IDLE.
- busy_mask reflects the registered FIFO contents. A bit clears on the edge that pops its last matching entry.
- A W write to a register whose busy_mask bit is set is a hazard-unit violation. The arbiter does not reorder; the bench asserts this never occurs.

Optional Feature:
- Macro RF_ARB_TRACE_EN.
- Defined: on every clock edge with rf_we=1 and reset deasserted, the block prints "%d@%h: $%d <= %h" using $time, rf_wpc, rf_a3 and rf_wd. This is simulation-only.
- Undefined: no trace logic is compiled and behaviour is otherwise identical.

Decomposition:
- Package rf_arb_pkg contains:
  - REG_W=5 and DATA_W=32;
  - the state enum (IDLE, WAIT, FORCE);
  - the entry struct typedef {a3, wd, pc}.
- One sub-module, rf_arb_fifo: circular buffer with read/write pointers, count, full/empty flags and busy_mask generation.
- The top level holds the grant logic, starvation counter and FSM.

Test Plan:
1. After reset release, push md a3=5, wd=0xDEADBEEF with w_we=0. Expect next cycle rf_we=1, rf_a3=5, rf_wd=0xDEADBEEF and busy_mask=0x20 during that cycle, then busy_mask=0.
2. Hold w_we=1 with w_a3=8 and push md a3=9 (STARVE_MAX=4). Expect four cycles of rf_a3=8, then one cycle with w_stall=1 and rf_a3=9, then rf_a3=8 resumes with the held W data.
3. With W continuously writing, push 2 entries (DEPTH=2). Expect md_ready=0 on the third cycle and md_ready=1 on the cycle after the first forced pop.
4. Push md a3=0 with md_valid=1. Expect md_ready stays 1, no rf_we and busy_mask=0. Also drive w_we=1 with w_a3=0 and expect rf_we=0.
5. With 2 entries pending, assert reset. Expect rf_we=0, w_stall=0, md_ready=0 and busy_mask=0 immediately; after release, no stale write over 10 cycles.
6. With RF_ARB_TRACE_EN defined, perform 3 mixed writes. Expect exactly 3 trace lines with the correct PC, register and data.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file write-port arbiter: widths, the
// arbiter state enum and the mult/div FIFO entry layout.
package rf_arb_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [REG_W-1:0]  a3;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] pc;
  } rf_entry_t;

endpackage

// File: rtl/rf_arb_fifo.sv
// Circular buffer holding pending mult/div register writes. Exposes the
// head entry, occupancy flags and a one-hot mask of every destination
// register that still has a pending entry.
module rf_arb_fifo
  import rf_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  rf_entry_t       din,
  output rf_entry_t       head,
  output logic            full,
  output logic            empty,
  output logic [CW-1:0]   count,
  output logic [31:0]     busy_mask
);

  rf_entry_t      mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  off;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; contents are qualified by the pointers so no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Busy mask: OR of one-hot destinations over the occupied slots
  always_comb begin
    busy_mask = '0;
    off       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rd_ptr;
      if ({1'b0, off} < count) busy_mask = busy_mask | (32'd1 << mem[i].a3);
    end
  end

endmodule

// File: rtl/rf_wport_arb.sv
// Register-file write-port arbiter. The W stage has fixed priority; the
// multi-cycle mult/div unit queues writes in a small FIFO and a starvation
// counter forces a one-cycle W stall once the head has waited STARVE_MAX
// cycles. Optional macro RF_ARB_TRACE_EN adds a simulation-only write trace.
module rf_wport_arb
  import rf_arb_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              w_we,
  input  logic [REG_W-1:0]  w_a3,
  input  logic [DATA_W-1:0] w_wd,
  input  logic [DATA_W-1:0] w_pc,
  output logic              w_stall,
  input  logic              md_valid,
  output logic              md_ready,
  input  logic [REG_W-1:0]  md_a3,
  input  logic [DATA_W-1:0] md_wd,
  input  logic [DATA_W-1:0] md_pc,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_a3,
  output logic [DATA_W-1:0] rf_wd,
  output logic [DATA_W-1:0] rf_wpc,
  output logic [31:0]       busy_mask
);

  localparam int        CW      = $clog2(DEPTH) + 1;
  localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

  arb_state_t       state;
  logic [3:0]       starve_cnt;
  rf_entry_t        md_entry;
  rf_entry_t        head;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic [CW-1:0]    left;
  logic [31:0]      fifo_busy;
  logic             push;
  logic             push_st;
  logic             pop;
  logic             grant_w;
  logic             grant_head;
  logic             nonempty_nxt;

  assign md_entry = {md_a3, md_wd, md_pc};

  // A request to r0 is acknowledged but never occupies a slot
  assign md_ready     = reset && !full;
  assign push         = md_valid && md_ready;
  assign push_st      = push && (md_a3 != '0);
  assign pop          = grant_head;
  assign left         = count + CW'(push_st) - CW'(pop);
  assign nonempty_nxt = (left != '0);
  assign w_stall      = reset && (state == FORCE);
  assign busy_mask    = reset ? fifo_busy : '0;

  rf_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_st),
    .pop       (pop),
    .din       (md_entry),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .busy_mask (fifo_busy)
  );

  // Priority grant: forced head, then W (non-r0), then any queued head
  always_comb begin
    grant_w    = 1'b0;
    grant_head = 1'b0;
    if (reset) begin
      if (state == FORCE && !empty)   grant_head = 1'b1;
      else if (w_we && w_a3 != '0)    grant_w    = 1'b1;
      else if (!empty)                grant_head = 1'b1;
    end
  end

  // Write-port mux driven by the granted source
  always_comb begin
    rf_we  = 1'b0;
    rf_a3  = '0;
    rf_wd  = '0;
    rf_wpc = '0;
    if (grant_w) begin
      rf_we  = 1'b1;
      rf_a3  = w_a3;
      rf_wd  = w_wd;
      rf_wpc = w_pc;
    end else if (grant_head) begin
      rf_we  = 1'b1;
      rf_a3  = head.a3;
      rf_wd  = head.wd;
      rf_wpc = head.pc;
    end
  end

  // Starvation FSM: count cycles the head is bypassed, force one grant at the limit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          starve_cnt <= '0;
          if (nonempty_nxt) state <= WAIT;
        end
        WAIT: begin
          if (!nonempty_nxt) begin
            state      <= IDLE;
            starve_cnt <= '0;
          end else if (pop) begin
            starve_cnt <= '0;
          end else if (starve_cnt + 4'd1 == CNT_MAX) begin
            state      <= FORCE;
            starve_cnt <= CNT_MAX;
          end else begin
            starve_cnt <= starve_cnt + 4'd1;
          end
        end
        FORCE: begin
          starve_cnt <= '0;
          state      <= nonempty_nxt ? WAIT : IDLE;
        end
        default: begin
          state      <= IDLE;
          starve_cnt <= '0;
        end
      endcase
    end
  end

`ifdef RF_ARB_TRACE_EN
  // Simulation-only trace of every granted register-file write
  always @(posedge clk) begin
    if (reset && rf_we) $display("%d@%h: $%d <= %h", $time, rf_wpc, rf_a3, rf_wd);
  end
`endif

endmodule

// File: tb/tb_rf_wport_arb.sv
// Self-checking bench for rf_wport_arb: directed scenarios followed by
// randomized traffic, checked against a queue-based reference model with a
// scoreboard monitor comparing every register-file write.
module tb_rf_wport_arb;

  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        w_we;
  logic [4:0]  w_a3;
  logic [31:0] w_wd;
  logic [31:0] w_pc;
  logic        w_stall;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_a3;
  logic [31:0] md_wd;
  logic [31:0] md_pc;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;
  logic [31:0] rf_wpc;
  logic [31:0] busy_mask;

  always #5 clk = ~clk;

  rf_wport_arb #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk       (clk),
    .reset     (reset),
    .w_we      (w_we),
    .w_a3      (w_a3),
    .w_wd      (w_wd),
    .w_pc      (w_pc),
    .w_stall   (w_stall),
    .md_valid  (md_valid),
    .md_ready  (md_ready),
    .md_a3     (md_a3),
    .md_wd     (md_wd),
    .md_pc     (md_pc),
    .rf_we     (rf_we),
    .rf_a3     (rf_a3),
    .rf_wd     (rf_wd),
    .rf_wpc    (rf_wpc),
    .busy_mask (busy_mask)
  );

  typedef struct {
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
  } wr_t;

  // Reference model: pending mult/div writes, bypass age of the head, force flag
  wr_t q[$];
  wr_t exp_q[$];
  int  m_wait  = 0;
  bit  m_force = 1'b0;

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int stall_cyc = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] m;
    m = '0;
    foreach (q[i]) m = m | (32'd1 << q[i].a3);
    return m;
  endfunction

  // One clock cycle: called at posedge+1, returns at the next posedge+1
  task automatic step(input logic wwe, input logic [4:0] wa3, input logic [31:0] wwd,
                      input logic [31:0] wpc, input logic mv, input logic [4:0] ma3,
                      input logic [31:0] mwd, input logic [31:0] mpc);
    logic        rdy;
    logic [31:0] bm;
    bit          gh, gw, had, pushed;
    wr_t         t;
    w_we = wwe; w_a3 = wa3; w_wd = wwd; w_pc = wpc;
    md_valid = mv; md_a3 = ma3; md_wd = mwd; md_pc = mpc;
    rdy = (q.size() < DEPTH);
    bm  = model_busy();
    gh  = 1'b0;
    gw  = 1'b0;
    if (m_force)                gh = 1'b1;
    else if (wwe && wa3 != 0)   gw = 1'b1;
    else if (q.size() > 0)      gh = 1'b1;
    if (gw) begin
      t.a3 = wa3; t.wd = wwd; t.pc = wpc;
      exp_q.push_back(t);
    end else if (gh) begin
      exp_q.push_back(q[0]);
    end
    #2;
    chk("md_ready",  32'(md_ready), 32'(rdy));
    chk("w_stall",   32'(w_stall),  32'(m_force));
    chk("busy_mask", busy_mask,     bm);
    chk("rf_we",     32'(rf_we),    32'(gw | gh));
    if (w_stall) stall_cyc = cyc;
    if (w_we && w_a3 != 0 && busy_mask[w_a3]) begin
      errors++;
      $display("FAIL hazard: W writes busy reg %0d (cycle %0d)", w_a3, cyc);
    end
    had    = (q.size() > 0);
    pushed = mv && rdy;
    if (gh) t = q.pop_front();
    if (pushed && ma3 != 0) begin
      t.a3 = ma3; t.wd = mwd; t.pc = mpc;
      q.push_back(t);
    end
    if (gh || q.size() == 0) begin
      m_wait  = 0;
      m_force = 1'b0;
    end else if (had) begin
      m_wait++;
      if (m_wait == STARVE_MAX) begin
        m_force = 1'b1;
        m_wait  = 0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0);
  endtask

  task automatic reset_outputs_check();
    chk("rst_rf_we",     32'(rf_we),    32'd0);
    chk("rst_w_stall",   32'(w_stall),  32'd0);
    chk("rst_md_ready",  32'(md_ready), 32'd0);
    chk("rst_busy_mask", busy_mask,     32'd0);
    chk("rst_rf_a3",     32'(rf_a3),    32'd0);
    chk("rst_rf_wd",     rf_wd,         32'd0);
    chk("rst_rf_wpc",    rf_wpc,        32'd0);
  endtask

  // Scoreboard monitor: every DUT write must match the oldest expected write
  always @(negedge clk) begin : mon
    wr_t e;
    if (reset && rf_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: a3=%0d wd=%h pc=%h (cycle %0d)", rf_a3, rf_wd, rf_wpc, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("rf_a3",  32'(rf_a3), 32'(e.a3));
        chk("rf_wd",  rf_wd,      e.wd);
        chk("rf_wpc", rf_wpc,     e.pc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic        pw_we;
    logic [4:0]  pw_a3;
    logic [31:0] pw_wd, pw_pc;
    logic [31:0] bm;
    logic        mv;
    logic [4:0]  ma3;
    bit          held;
    int          push_c;

    reset = 1'b0;
    w_we = 0; w_a3 = 0; w_wd = 0; w_pc = 0;
    md_valid = 0; md_a3 = 0; md_wd = 0; md_pc = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_outputs_check();
    reset = 1'b1;

    // Single mult/div write on an idle port
    step(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF, 32'h0000_0100);
    idle();
    idle();

    // Continuous W traffic starves the head until a forced grant
    push_c = cyc;
    step(1'b1, 5'd8, 32'h1111_1111, 32'h0000_0200, 1'b1, 5'd9, 32'h9999_9999, 32'h0000_0204);
    repeat (7) step(1'b1, 5'd8, 32'h1111_1111, 32'h0000_0200, 1'b0, 5'd0, 32'd0, 32'd0);
    chk("force_cycle", 32'(stall_cyc), 32'(push_c + STARVE_MAX + 1));

    // Fill the FIFO under W traffic; ready drops when full, returns after a forced pop
    step(1'b1, 5'd8, 32'h2222_2222, 32'h0000_0300, 1'b1, 5'd10, 32'hA0A0_A0A0, 32'h0000_0304);
    step(1'b1, 5'd8, 32'h2222_2222, 32'h0000_0300, 1'b1, 5'd11, 32'hB1B1_B1B1, 32'h0000_0308);
    repeat (12) step(1'b1, 5'd8, 32'h2222_2222, 32'h0000_0300, 1'b1, 5'd12, 32'hC2C2_C2C2, 32'h0000_030C);
    repeat (12) step(1'b1, 5'd8, 32'h2222_2222, 32'h0000_0300, 1'b0, 5'd0, 32'd0, 32'd0);

    // Writes to r0 from either source are swallowed
    repeat (3) step(1'b1, 5'd0, 32'h3333_3333, 32'h0000_0400, 1'b1, 5'd0, 32'h4444_4444, 32'h0000_0404);
    idle();

    // Reset with two entries pending discards them
    step(1'b1, 5'd8, 32'h5555_5555, 32'h0000_0500, 1'b1, 5'd13, 32'hD3D3_D3D3, 32'h0000_0504);
    step(1'b1, 5'd8, 32'h5555_5555, 32'h0000_0500, 1'b1, 5'd14, 32'hE4E4_E4E4, 32'h0000_0508);
    w_we = 0; md_valid = 0;
    reset = 1'b0;
    #1;
    reset_outputs_check();
    q.delete();
    m_wait  = 0;
    m_force = 1'b0;
    @(posedge clk);
    #1;
    reset_outputs_check();
    chk("exp_drained_at_reset", 32'(exp_q.size()), 32'd0);
    reset = 1'b1;
    repeat (10) idle();

    // Randomized traffic; W is held during a stall and avoids busy registers
    held  = 1'b0;
    pw_we = 0; pw_a3 = 0; pw_wd = 0; pw_pc = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!held) begin
        pw_we = ($urandom_range(0, 3) != 0);
        bm    = model_busy();
        do pw_a3 = 5'($urandom_range(0, 15)); while (bm[pw_a3]);
        pw_wd = $urandom;
        pw_pc = $urandom & 32'hFFFF_FFFC;
      end
      mv  = ($urandom_range(0, 2) == 0);
      ma3 = 5'($urandom_range(0, 7));
      if (m_force && pw_we && pw_a3 != 0 && ma3 == pw_a3) mv = 1'b0;
      held = m_force;
      step(pw_we, pw_a3, pw_wd, pw_pc, mv, ma3, $urandom, $urandom & 32'hFFFF_FFFC);
    end
    repeat (20) idle();
    chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
